// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
//
// Consumer end of the T0..T7 one-hot timing-beat ring of the 8-bit CPU.
// Samples the beat bus and the instruction byte on every rising edge and
// issues the registered micro-operation strobes for the sampled beat. An HLT
// opcode decoded at T2 raises the sticky halt back to the beat generator.
//
// Optional feature macro: BEAT_CHECK_EN
//   defined   : a broken beat ring (not one-hot, or out of sequence) seen in
//               RUN moves the block to FAULT (fault=1, halt=1) until rst.
//   undefined : no ring checking, fault is tied low, the lowest set bit of
//               t_beat selects the beat and t_beat == 0 issues nothing.
//
// Ports
//   clk        in   1        system clock, rising edge
//   rst        in   1        synchronous reset, active-high, wins over all
//   t_beat     in   8        beat bus, t_beat[k] = Tk
//   instr      in   OP+ADDR  memory data bus (opcode | operand)
//   mar_src    out  1        0 = PC->MAR, 1 = IR operand->MAR
//   mar_ld     out  1        load MAR
//   mem_rd     out  1        memory read enable
//   ir_ld      out  1        load IR from instr
//   pc_inc     out  1        increment PC
//   acc_ld     out  1        load ACC
//   b_ld       out  1        load ALU B register
//   alu_sub    out  1        0 = add, 1 = subtract
//   out_ld     out  1        load output port from ACC
//   halt       out  1        stop the beat generator; sticky
//   fault      out  1        beat-ring error; sticky
//   instr_done out  1        one-cycle pulse when an instruction retires
//   retired    out  CNT_W    retired-instruction count, wraps to 0
// -----------------------------------------------------------------------------
module beat_sequencer #(
    parameter int OP_W   = 4,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             t_beat,
    input  logic [OP_W+ADDR_W-1:0] instr,
    output logic                   mar_src,
    output logic                   mar_ld,
    output logic                   mem_rd,
    output logic                   ir_ld,
    output logic                   pc_inc,
    output logic                   acc_ld,
    output logic                   b_ld,
    output logic                   alu_sub,
    output logic                   out_ld,
    output logic                   halt,
    output logic                   fault,
    output logic                   instr_done,
    output logic [CNT_W-1:0]       retired
);

    localparam int IR_W = OP_W + ADDR_W;

    localparam logic [OP_W-1:0] OP_NOP = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    typedef struct packed {
        logic mar_src;
        logic mar_ld;
        logic mem_rd;
        logic ir_ld;
        logic pc_inc;
        logic acc_ld;
        logic b_ld;
        logic alu_sub;
        logic out_ld;
    } strobe_t;

    localparam strobe_t STROBE_NONE = strobe_t'(9'h000);

    // Even parity over the IR contents.
    function automatic logic parity_of(input logic [IR_W-1:0] v);
        return ^v;
    endfunction

    // Lowest set bit of the beat bus: {found, index}.
    function automatic logic [3:0] lowest_beat(input logic [7:0] v);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

`ifdef BEAT_CHECK_EN
    // Exactly one bit set.
    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction
`endif

    state_t             state_r;
    state_t             state_nxt_s;
    logic [IR_W-1:0]    ir_r;
    logic [IR_W-1:0]    ir_nxt_s;
    logic               ir_par_r;
    logic               ir_par_nxt_s;
    strobe_t            strobe_r;
    strobe_t            strobe_nxt_s;
    logic               halt_r;
    logic               halt_nxt_s;
    logic               done_r;
    logic               done_nxt_s;
    logic [CNT_W-1:0]   retired_r;
    logic [CNT_W-1:0]   retired_nxt_s;

    logic [3:0]         sel_s;
    logic               sel_valid_s;
    logic [2:0]         sel_idx_s;
    logic               beat_go_s;
    logic [2:0]         beat_idx_s;

    logic [OP_W-1:0]    opcode_s;
    logic               op_lda_s;
    logic               op_alu_s;
    logic               op_mem_s;

`ifdef BEAT_CHECK_EN
    logic [2:0]         prev_beat_r;
    logic [2:0]         prev_nxt_s;
    logic [2:0]         exp_beat_s;
    logic               fault_r;
    logic               fault_nxt_s;
`endif

    assign sel_s       = lowest_beat(t_beat);
    assign sel_valid_s = sel_s[3];
    assign sel_idx_s   = sel_s[2:0];

    // An IR whose stored parity no longer matches is executed as NOP, so an
    // upset register can never issue an unintended load or halt.
    assign opcode_s = (parity_of(ir_r) == ir_par_r) ? ir_r[IR_W-1:ADDR_W] : OP_NOP;
    assign op_lda_s = (opcode_s == OP_LDA);
    assign op_alu_s = (opcode_s == OP_ADD) || (opcode_s == OP_SUB);
    assign op_mem_s = op_lda_s || op_alu_s;

`ifdef BEAT_CHECK_EN
    assign exp_beat_s = prev_beat_r + 3'd1;
`endif

    // Next-state and next-output logic for the beat sequencer FSM.
    always_comb begin
        state_nxt_s   = state_r;
        ir_nxt_s      = ir_r;
        ir_par_nxt_s  = ir_par_r;
        strobe_nxt_s  = STROBE_NONE;
        halt_nxt_s    = 1'b0;
        done_nxt_s    = 1'b0;
        retired_nxt_s = retired_r;
        beat_go_s     = 1'b0;
        beat_idx_s    = 3'd0;
`ifdef BEAT_CHECK_EN
        prev_nxt_s    = prev_beat_r;
        fault_nxt_s   = 1'b0;
`endif

        case (state_r)
            ST_IDLE: begin
                // Only a clean T0 starts the sequencer; its strobes issue at once.
                if (t_beat == 8'h01) begin
                    state_nxt_s = ST_RUN;
                    beat_go_s   = 1'b1;
                    beat_idx_s  = 3'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef BEAT_CHECK_EN
                if (is_one_hot(t_beat) && sel_valid_s && (sel_idx_s == exp_beat_s)) begin
                    beat_go_s  = 1'b1;
                    beat_idx_s = sel_idx_s;
                end else begin
                    state_nxt_s = ST_FAULT;
                    fault_nxt_s = 1'b1;
                    halt_nxt_s  = 1'b1;
                end
`else
                // An empty beat bus simply holds; multi-hot takes the lowest beat.
                if (sel_valid_s) begin
                    beat_go_s  = 1'b1;
                    beat_idx_s = sel_idx_s;
                end else begin
                    state_nxt_s = ST_RUN;
                end
`endif
            end
            ST_HALTED: begin
                halt_nxt_s = 1'b1;
            end
            ST_FAULT: begin
                halt_nxt_s  = 1'b1;
`ifdef BEAT_CHECK_EN
                fault_nxt_s = 1'b1;
`endif
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (beat_go_s) begin
`ifdef BEAT_CHECK_EN
            prev_nxt_s = beat_idx_s;
`endif
            case (beat_idx_s)
                3'd0: begin
                    strobe_nxt_s.mar_src = 1'b0;
                    strobe_nxt_s.mar_ld  = 1'b1;
                end
                3'd1: begin
                    strobe_nxt_s.mem_rd = 1'b1;
                    strobe_nxt_s.ir_ld  = 1'b1;
                    strobe_nxt_s.pc_inc = 1'b1;
                    ir_nxt_s            = instr;
                    ir_par_nxt_s        = parity_of(instr);
                end
                3'd2: begin
                    if (opcode_s == OP_HLT) begin
                        state_nxt_s = ST_HALTED;
                        halt_nxt_s  = 1'b1;
                    end else begin
                        halt_nxt_s  = 1'b0;
                    end
                end
                3'd3: begin
                    if (op_mem_s) begin
                        strobe_nxt_s.mar_src = 1'b1;
                        strobe_nxt_s.mar_ld  = 1'b1;
                    end else begin
                        strobe_nxt_s = STROBE_NONE;
                    end
                end
                3'd4: begin
                    if (op_lda_s) begin
                        strobe_nxt_s.mem_rd = 1'b1;
                        strobe_nxt_s.acc_ld = 1'b1;
                    end else if (op_alu_s) begin
                        strobe_nxt_s.mem_rd = 1'b1;
                        strobe_nxt_s.b_ld   = 1'b1;
                    end else begin
                        strobe_nxt_s = STROBE_NONE;
                    end
                end
                3'd5: begin
                    if (op_alu_s) begin
                        strobe_nxt_s.acc_ld  = 1'b1;
                        strobe_nxt_s.alu_sub = (opcode_s == OP_SUB);
                    end else begin
                        strobe_nxt_s = STROBE_NONE;
                    end
                end
                3'd6: begin
                    if (opcode_s == OP_OUT) begin
                        strobe_nxt_s.out_ld = 1'b1;
                    end else begin
                        strobe_nxt_s = STROBE_NONE;
                    end
                end
                3'd7: begin
                    done_nxt_s    = 1'b1;
                    retired_nxt_s = retired_r + CNT_W'(1);
                end
                default: begin
                    strobe_nxt_s = STROBE_NONE;
                end
            endcase
        end else begin
            beat_idx_s = 3'd0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered strobes, IR and retirement counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_r      <= {IR_W{1'b0}};
            ir_par_r  <= 1'b0;
            strobe_r  <= STROBE_NONE;
            halt_r    <= 1'b0;
            done_r    <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            ir_r      <= ir_nxt_s;
            ir_par_r  <= ir_par_nxt_s;
            strobe_r  <= strobe_nxt_s;
            halt_r    <= halt_nxt_s;
            done_r    <= done_nxt_s;
            retired_r <= retired_nxt_s;
        end
    end

`ifdef BEAT_CHECK_EN
    // Ring-check history and sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_beat_r <= 3'd0;
            fault_r     <= 1'b0;
        end else begin
            prev_beat_r <= prev_nxt_s;
            fault_r     <= fault_nxt_s;
        end
    end

    assign fault = fault_r;
`else
    assign fault = 1'b0;
`endif

    assign mar_src    = strobe_r.mar_src;
    assign mar_ld     = strobe_r.mar_ld;
    assign mem_rd     = strobe_r.mem_rd;
    assign ir_ld      = strobe_r.ir_ld;
    assign pc_inc     = strobe_r.pc_inc;
    assign acc_ld     = strobe_r.acc_ld;
    assign b_ld       = strobe_r.b_ld;
    assign alu_sub    = strobe_r.alu_sub;
    assign out_ld     = strobe_r.out_ld;
    assign halt       = halt_r;
    assign instr_done = done_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
//
// Scoreboard bench for beat_sequencer. A driver applies one input vector per
// cycle on the falling edge and pushes the outputs a behavioural model
// predicts for the next rising edge; a monitor pops and compares one entry
// shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_HALTED = 2;
    localparam int M_FAULT  = 3;

    typedef logic [19:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] t_beat;
    logic [7:0] instr;
    logic       mar_src, mar_ld, mem_rd, ir_ld, pc_inc;
    logic       acc_ld, b_ld, alu_sub, out_ld;
    logic       halt, fault, instr_done;
    logic [7:0] retired;

    vec_t exp_q[$];
    vec_t exp_v;
    vec_t got_v;
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state.
    int         m_mode    = M_IDLE;
    int         m_prev    = 0;
    logic [7:0] m_ir      = 8'h00;
    int         m_retired = 0;

    int ring_k = 0;
    int stuck  = 0;

    always #5 clk = ~clk;

    beat_sequencer #(
        .OP_W   (4),
        .ADDR_W (4),
        .CNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .t_beat     (t_beat),
        .instr      (instr),
        .mar_src    (mar_src),
        .mar_ld     (mar_ld),
        .mem_rd     (mem_rd),
        .ir_ld      (ir_ld),
        .pc_inc     (pc_inc),
        .acc_ld     (acc_ld),
        .b_ld       (b_ld),
        .alu_sub    (alu_sub),
        .out_ld     (out_ld),
        .halt       (halt),
        .fault      (fault),
        .instr_done (instr_done),
        .retired    (retired)
    );

    // Strobes for beat k of opcode op, bit order:
    // {mar_src, mar_ld, mem_rd, ir_ld, pc_inc, acc_ld, b_ld, alu_sub, out_ld}
    function automatic logic [8:0] sched(input int beat, input logic [3:0] op);
        logic [8:0] s;
        logic       is_alu;
        s      = 9'h000;
        is_alu = (op == 4'h2) || (op == 4'h3);
        if (beat == 0) s[7] = 1'b1;
        if (beat == 1) s[6:4] = 3'b111;
        if (beat == 3 && (op == 4'h1 || is_alu)) s[8:7] = 2'b11;
        if (beat == 4 && op == 4'h1) begin s[6] = 1'b1; s[3] = 1'b1; end
        if (beat == 4 && is_alu) begin s[6] = 1'b1; s[2] = 1'b1; end
        if (beat == 5 && is_alu) begin s[3] = 1'b1; s[1] = (op == 4'h3); end
        if (beat == 6 && op == 4'h4) s[0] = 1'b1;
        return s;
    endfunction

    // Advance the model by one clock edge and return the predicted outputs.
    task automatic model_step(input logic r, input logic [7:0] tb,
                              input logic [7:0] ins, output vec_t e);
        logic [8:0] s;
        logic       d;
        int         k;
        s = 9'h000;
        d = 1'b0;
        k = -1;
        if (r) begin
            m_mode    = M_IDLE;
            m_ir      = 8'h00;
            m_retired = 0;
            m_prev    = 0;
        end else if (m_mode == M_IDLE) begin
            if (tb === 8'h01) begin
                m_mode = M_RUN;
                k      = 0;
            end
        end else if (m_mode == M_RUN) begin
`ifdef BEAT_CHECK_EN
            if ($countones(tb) != 1 || tb != (8'h01 << ((m_prev + 1) % 8)))
                m_mode = M_FAULT;
            else
                k = (m_prev + 1) % 8;
`else
            for (int i = 7; i >= 0; i--)
                if (tb[i]) k = i;
`endif
        end
        if (k >= 0) begin
            m_prev = k;
            if (k == 1) m_ir = ins;
            if (k == 2 && m_ir[7:4] == 4'hF) m_mode = M_HALTED;
            else s = sched(k, m_ir[7:4]);
            if (k == 7) begin
                d         = 1'b1;
                m_retired = (m_retired + 1) % 256;
            end
        end
        e = {s, (m_mode == M_HALTED || m_mode == M_FAULT), (m_mode == M_FAULT), d, 8'(m_retired)};
    endtask

    // Apply one input vector and log its expected response.
    task automatic step(input logic r, input logic [7:0] tb, input logic [7:0] ins);
        vec_t e;
        @(negedge clk);
        rst    = r;
        t_beat = tb;
        instr  = ins;
        model_step(r, tb, ins, e);
        exp_q.push_back(e);
    endtask

    // One full T0..T7 instruction; instr is noise except at T1.
    task automatic run_instr(input logic [7:0] op_byte);
        for (int k = 0; k < 8; k++)
            step(1'b0, 8'h01 << k, (k == 1) ? op_byte : 8'($urandom));
    endtask

    function automatic logic [3:0] pick_op();
        int r;
        r = $urandom_range(0, 6);
        if (r <= 4) return 4'(r);
        return 4'($urandom_range(5, 14));
    endfunction

    // Monitor: compare the DUT outputs with the oldest scoreboard entry.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {mar_src, mar_ld, mem_rd, ir_ld, pc_inc, acc_ld, b_ld,
                     alu_sub, out_ld, halt, fault, instr_done, retired};
            vectors++;
            if (got_v !== exp_v) begin
                miscompares++;
                $display("FAIL outputs @%0t: got %05h expected %05h", $time, got_v, exp_v);
            end
        end
    end

    // Stimulus.
    initial begin
        rst    = 1'b1;
        t_beat = 8'h00;
        instr  = 8'h00;

        // Reset, then idle with beats that must not start the sequencer.
        step(1'b1, 8'h00, 8'h00);
        step(1'b1, 8'h01, 8'h00);
        step(1'b0, 8'h02, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h80, 8'h00);

        // Directed opcodes: LDA, SUB, ADD, OUT, NOP, undefined.
        run_instr(8'h1A);
        run_instr(8'h35);
        run_instr(8'h27);
        run_instr(8'h4C);
        run_instr(8'h03);
        run_instr(8'h9E);

        // Random instruction stream.
        repeat (40) run_instr({pick_op(), 4'($urandom)});

        // Reset in the middle of an LDA at T4, then stray beats before T0.
        for (int k = 0; k < 4; k++) step(1'b0, 8'h01 << k, 8'h1A);
        step(1'b1, 8'h10, 8'h1A);
        step(1'b0, 8'h20, 8'h1A);
        step(1'b0, 8'h40, 8'h1A);
        step(1'b0, 8'h80, 8'h1A);
        run_instr(8'h21);

        // HLT: halt sticks whatever the beat bus does.
        step(1'b0, 8'h01, 8'h00);
        step(1'b0, 8'h02, 8'hF0);
        step(1'b0, 8'h04, 8'h00);
        step(1'b0, 8'hFF, 8'h12);
        step(1'b0, 8'h5A, 8'h34);
        step(1'b0, 8'hxx, 8'h56);
        for (int k = 3; k < 8; k++) step(1'b0, 8'h01 << k, 8'h00);
        step(1'b0, 8'h01, 8'h00);
        step(1'b1, 8'h00, 8'h00);

`ifdef BEAT_CHECK_EN
        // Skipped beat.
        step(1'b0, 8'h01, 8'h00);
        step(1'b0, 8'h02, 8'h23);
        step(1'b0, 8'h08, 8'h00);
        step(1'b0, 8'h10, 8'h00);
        step(1'b0, 8'h01, 8'h00);
        step(1'b1, 8'h00, 8'h00);
        // Empty beat bus.
        step(1'b0, 8'h01, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h02, 8'h00);
        step(1'b1, 8'h00, 8'h00);
        // Multi-hot beat.
        step(1'b0, 8'h01, 8'h00);
        step(1'b0, 8'h02, 8'h23);
        step(1'b0, 8'h0C, 8'h00);
        step(1'b0, 8'h08, 8'h00);
        step(1'b1, 8'h00, 8'h00);
`else
        // Empty beats hold, multi-hot selects the lowest beat.
        step(1'b0, 8'h01, 8'h00);
        step(1'b0, 8'h02, 8'h23);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h0C, 8'h00);
        step(1'b0, 8'h18, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h30, 8'h00);
        step(1'b0, 8'hE0, 8'h00);
        step(1'b0, 8'h40, 8'h00);
        step(1'b0, 8'h80, 8'h00);
        // Out-of-sequence jump straight to T6.
        step(1'b0, 8'h01, 8'h00);
        step(1'b0, 8'h02, 8'h47);
        step(1'b0, 8'h40, 8'h00);
        step(1'b0, 8'h80, 8'h00);
        step(1'b1, 8'h00, 8'h00);
`endif

        // Counter wrap: 256 NOPs from reset bring retired back to 0.
        repeat (256) run_instr({4'h0, 4'($urandom)});

        // Random ring with occasional corrupt beats and resets.
        ring_k = 0;
        stuck  = 0;
        repeat (300) begin
            if (stuck > 3 || $urandom_range(0, 59) == 0) begin
                stuck = 0;
                step(1'b1, 8'($urandom), 8'($urandom));
            end else begin
                step(1'b0, ($urandom_range(0, 9) == 0) ? 8'($urandom) : (8'h01 << ring_k),
                     8'($urandom));
            end
            ring_k = (ring_k + 1) % 8;
            if (m_mode == M_HALTED || m_mode == M_FAULT) stuck++;
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d entries pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
